// File: rtl/matrix_result_reader_pkg.sv
// Shared constants, reader state encoding and elaboration helpers for the
// matrix inverse engine result reader.
package matrix_result_reader_pkg;

  localparam int MAT_N        = 5;
  localparam int MAT_DATA_W   = 32;
  localparam int MAT_ADDR_W   = 5;
  localparam int MAT_NUM_ELEM = MAT_N * MAT_N;
  localparam int MAT_READ_LAT = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } rd_state_t;

  // Width of a down-counter that must hold the value lat (never zero bits).
  function automatic int lat_cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/matrix_result_reader_if.sv
// Engine read port plus element stream of the matrix result reader; the
// master modport is the reader, the slave modport is engine + consumer side.
interface matrix_result_reader_if #(
  parameter int DATA_W = matrix_result_reader_pkg::MAT_DATA_W,
  parameter int ADDR_W = matrix_result_reader_pkg::MAT_ADDR_W
);

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] elem_data;
  logic [2:0]        elem_row;
  logic [2:0]        elem_col;
  logic              elem_last;
  logic              elem_valid;
  logic              elem_ready;

  modport master (
    input  start, abort, data_in, elem_ready,
    output busy, done, address, elem_data, elem_row, elem_col, elem_last, elem_valid
  );

  modport slave (
    output start, abort, data_in, elem_ready,
    input  busy, done, address, elem_data, elem_row, elem_col, elem_last, elem_valid
  );

endinterface

// File: rtl/matrix_result_reader_mat_index_counter.sv
// Row/column/linear-address walker over an N x N matrix; address tracks
// row*N+col purely by incrementing, so no multiplier or divider is needed.
module matrix_result_reader_mat_index_counter #(
  parameter int N      = matrix_result_reader_pkg::MAT_N,
  parameter int ADDR_W = matrix_result_reader_pkg::MAT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [2:0]        o_row,
  output logic [2:0]        o_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [2:0]        COL_MAX  = 3'(N - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(N * N - 1);

  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_inc) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
      r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_addr = r_addr;
  assign o_last = (r_addr == ADDR_MAX);

endmodule

// File: rtl/matrix_result_reader.sv
// Read-side initiator for the matrix inverse engine: walks every result address,
// waits out the read latency and hands each element downstream as a tagged stream.
module matrix_result_reader
  import matrix_result_reader_pkg::*;
#(
  parameter int N        = MAT_N,
  parameter int DATA_W   = MAT_DATA_W,
  parameter int ADDR_W   = MAT_ADDR_W,
  parameter int READ_LAT = MAT_READ_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_result_reader_if.master bus
);

  localparam int               LAT_W    = lat_cnt_width(READ_LAT);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0] r_elem_data;
  logic [2:0]        r_elem_row;
  logic [2:0]        r_elem_col;
  logic              r_elem_last;
  logic              r_elem_valid;

  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_lat_load;
  logic              w_capture;
  logic              w_accept;
  logic [2:0]        w_row;
  logic [2:0]        w_col;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;

  matrix_result_reader_mat_index_counter #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // abort overrides everything, including a handshake in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_lat_load  = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_cnt_clr   = 1'b1;
            w_lat_load  = 1'b1;
            w_state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (r_lat_cnt == '0) begin
            w_capture   = 1'b1;
            w_state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (bus.elem_ready) begin
            w_accept = 1'b1;
            if (r_elem_last) begin
              w_state_nxt = DONE;
            end else begin
              w_cnt_inc   = 1'b1;
              w_lat_load  = 1'b1;
              w_state_nxt = WAIT;
            end
          end
        end
        DONE: begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cnt <= '0;
    end else if (w_lat_load) begin
      r_lat_cnt <= LAT_INIT;
    end else if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  // Output capture register: holds the element stable for any stall length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_elem_data  <= '0;
      r_elem_row   <= '0;
      r_elem_col   <= '0;
      r_elem_last  <= 1'b0;
      r_elem_valid <= 1'b0;
    end else if (w_capture) begin
      r_elem_data  <= bus.data_in;
      r_elem_row   <= w_row;
      r_elem_col   <= w_col;
      r_elem_last  <= w_last;
      r_elem_valid <= 1'b1;
    end else if (w_accept || bus.abort) begin
      r_elem_valid <= 1'b0;
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.address    = w_addr;
  assign bus.elem_data  = r_elem_data;
  assign bus.elem_row   = r_elem_row;
  assign bus.elem_col   = r_elem_col;
  assign bus.elem_last  = r_elem_last;
  assign bus.elem_valid = r_elem_valid;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Bench for matrix_result_reader: three builds (READ_LAT 0/1/3) against a ROM
// model returning 0x100+addr, with a scoreboard queue of expected elements.
module tb_matrix_result_reader;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
    logic        l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] t_start;
  logic [2:0] t_abort;
  logic [2:0] t_ready;
  int         sel;
  int         n_checks = 0;
  int         n_pass   = 0;
  exp_t       q[$];

  always #5 clk = ~clk;

  matrix_result_reader_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
  matrix_result_reader_if #(.DATA_W(32), .ADDR_W(5)) b1 ();
  matrix_result_reader_if #(.DATA_W(32), .ADDR_W(5)) b3 ();

  matrix_result_reader #(.N(5), .DATA_W(32), .ADDR_W(5), .READ_LAT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
  matrix_result_reader #(.N(5), .DATA_W(32), .ADDR_W(5), .READ_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  matrix_result_reader #(.N(5), .DATA_W(32), .ADDR_W(5), .READ_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  assign b0.start = t_start[0];
  assign b1.start = t_start[1];
  assign b3.start = t_start[2];
  assign b0.abort = t_abort[0];
  assign b1.abort = t_abort[1];
  assign b3.abort = t_abort[2];
  assign b0.elem_ready = t_ready[0];
  assign b1.elem_ready = t_ready[1];
  assign b3.elem_ready = t_ready[2];

  // Engine ROM models: data = 0x100 + address after READ_LAT cycles
  logic [31:0] rom1_q;
  logic [31:0] rom3_q [3];
  always @(posedge clk) rom1_q <= 32'h100 + 32'(b1.address);
  always @(posedge clk) begin
    rom3_q[0] <= 32'h100 + 32'(b3.address);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign b0.data_in = 32'h100 + 32'(b0.address);
  assign b1.data_in = rom1_q;
  assign b3.data_in = rom3_q[2];

  // View of the build currently under test
  logic        m_valid, m_last, m_busy, m_done;
  logic [31:0] m_data;
  logic [2:0]  m_row, m_col;
  logic [4:0]  m_addr;
  assign m_valid = (sel == 0) ? b0.elem_valid : (sel == 2) ? b3.elem_valid : b1.elem_valid;
  assign m_last  = (sel == 0) ? b0.elem_last  : (sel == 2) ? b3.elem_last  : b1.elem_last;
  assign m_busy  = (sel == 0) ? b0.busy       : (sel == 2) ? b3.busy       : b1.busy;
  assign m_done  = (sel == 0) ? b0.done       : (sel == 2) ? b3.done       : b1.done;
  assign m_data  = (sel == 0) ? b0.elem_data  : (sel == 2) ? b3.elem_data  : b1.elem_data;
  assign m_row   = (sel == 0) ? b0.elem_row   : (sel == 2) ? b3.elem_row   : b1.elem_row;
  assign m_col   = (sel == 0) ? b0.elem_col   : (sel == 2) ? b3.elem_col   : b1.elem_col;
  assign m_addr  = (sel == 0) ? b0.address    : (sel == 2) ? b3.address    : b1.address;

  task automatic push_matrix();
    exp_t e;
    q.delete();
    for (int i = 0; i < 25; i++) begin
      e.d = 32'h100 + 32'(i);
      e.r = 3'(i / 5);
      e.c = 3'(i % 5);
      e.l = (i == 24);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    t_start[sel] = 1'b1;
    @(negedge clk);
    t_start[sel] = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1;
    @(negedge clk);
    n_checks++; if (m_busy !== 1'b0)     $display("FAIL reset_busy got %b exp 0", m_busy);       else n_pass++;
    n_checks++; if (m_done !== 1'b0)     $display("FAIL reset_done got %b exp 0", m_done);       else n_pass++;
    n_checks++; if (m_valid !== 1'b0)    $display("FAIL reset_valid got %b exp 0", m_valid);     else n_pass++;
    n_checks++; if (m_addr !== 5'd0)     $display("FAIL reset_addr got %0d exp 0", m_addr);      else n_pass++;
    n_checks++; if (m_data !== 32'h0)    $display("FAIL reset_data got %h exp 0", m_data);       else n_pass++;
    n_checks++; if ({m_row, m_col, m_last} !== 7'd0) $display("FAIL reset_rowcol got %b exp 0", {m_row, m_col, m_last}); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (m_busy !== 1'b0)     $display("FAIL idle_busy got %b exp 0", m_busy);        else n_pass++;
  endtask

  task automatic test_stream(input int s, input int lat);
    exp_t e;
    int got, last_hs, done_c;
    sel = s;
    push_matrix();
    t_ready[s] = 1'b1;
    pulse_start();
    got = 0; last_hs = -1; done_c = -1;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      @(negedge clk);
      if (m_valid) begin
        if (q.size() == 0) begin
          n_checks++; $display("FAIL lat%0d_extra got %h exp none", lat, m_data);
        end else begin
          e = q.pop_front();
          n_checks++; if (m_data !== e.d) $display("FAIL lat%0d_data got %h exp %h", lat, m_data, e.d); else n_pass++;
          n_checks++; if (m_row !== e.r)  $display("FAIL lat%0d_row got %0d exp %0d", lat, m_row, e.r); else n_pass++;
          n_checks++; if (m_col !== e.c)  $display("FAIL lat%0d_col got %0d exp %0d", lat, m_col, e.c); else n_pass++;
          n_checks++; if (m_last !== e.l) $display("FAIL lat%0d_last got %b exp %b", lat, m_last, e.l); else n_pass++;
          n_checks++; if (m_addr !== 5'(got)) $display("FAIL lat%0d_addr got %0d exp %0d", lat, m_addr, got); else n_pass++;
          n_checks++;
          if (got == 0) begin
            if (c != lat) $display("FAIL lat%0d_first got cycle %0d exp %0d", lat, c, lat); else n_pass++;
          end else begin
            if (c - last_hs != lat + 2) $display("FAIL lat%0d_spacing got %0d exp %0d", lat, c - last_hs, lat + 2); else n_pass++;
          end
          last_hs = c;
          got++;
        end
      end
      if (m_done) done_c = c;
    end
    n_checks++; if (got != 25) $display("FAIL lat%0d_count got %0d exp 25", lat, got); else n_pass++;
    n_checks++; if (done_c != last_hs + 1) $display("FAIL lat%0d_done_cycle got %0d exp %0d", lat, done_c, last_hs + 1); else n_pass++;
    @(negedge clk);
    n_checks++; if (m_busy !== 1'b0) $display("FAIL lat%0d_busy_after got %b exp 0", lat, m_busy); else n_pass++;
    n_checks++; if (m_done !== 1'b0) $display("FAIL lat%0d_done_width got %b exp 0", lat, m_done); else n_pass++;
    t_ready[s] = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    int got, stall, dones;
    sel = 1;
    push_matrix();
    t_ready[1] = 1'b1;
    pulse_start();
    got = 0; stall = 0; dones = 0;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      if (m_valid && m_data == 32'h107 && stall < 4) begin
        t_ready[1] = 1'b0;
        stall++;
        n_checks++; if (m_data !== 32'h107) $display("FAIL stall_data got %h exp 107", m_data); else n_pass++;
        n_checks++; if ({m_row, m_col} !== {3'd1, 3'd2}) $display("FAIL stall_rowcol got %0d/%0d exp 1/2", m_row, m_col); else n_pass++;
        n_checks++; if (m_addr !== 5'd7) $display("FAIL stall_addr got %0d exp 7", m_addr); else n_pass++;
      end else begin
        t_ready[1] = 1'b1;
      end
      if (m_valid && t_ready[1]) begin
        if (q.size() == 0) begin
          n_checks++; $display("FAIL stall_extra got %h exp none", m_data);
        end else begin
          e = q.pop_front();
          n_checks++; if ({m_data, m_row, m_col, m_last} !== {e.d, e.r, e.c, e.l}) $display("FAIL stall_elem got %h exp %h", m_data, e.d); else n_pass++;
          got++;
        end
      end
      if (m_done) dones++;
    end
    n_checks++; if (stall != 4) $display("FAIL stall_cycles got %0d exp 4", stall); else n_pass++;
    n_checks++; if (got != 25) $display("FAIL stall_count got %0d exp 25", got); else n_pass++;
    n_checks++; if (dones != 1) $display("FAIL stall_done got %0d exp 1", dones); else n_pass++;
    @(negedge clk);
    t_ready[1] = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    int got, extra;
    sel = 1;
    push_matrix();
    t_ready[1] = 1'b1;
    pulse_start();
    got = 0;
    for (int c = 0; c < 200 && got < 13; c++) begin
      @(negedge clk);
      if (m_valid) begin
        e = q.pop_front();
        n_checks++; if (m_data !== e.d) $display("FAIL abort_pre_data got %h exp %h", m_data, e.d); else n_pass++;
        got++;
      end
    end
    @(negedge clk);
    n_checks++; if (m_busy !== 1'b1) $display("FAIL abort_pre_busy got %b exp 1", m_busy); else n_pass++;
    t_abort[1] = 1'b1;
    @(negedge clk);
    t_abort[1] = 1'b0;
    n_checks++; if (m_busy !== 1'b0)  $display("FAIL abort_busy got %b exp 0", m_busy);    else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL abort_valid got %b exp 0", m_valid);  else n_pass++;
    n_checks++; if (m_addr !== 5'd0)  $display("FAIL abort_addr got %0d exp 0", m_addr);   else n_pass++;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid || m_done || m_busy) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL abort_quiet got %0d active cycles exp 0", extra); else n_pass++;
    t_abort[1] = 1'b1;
    t_start[1] = 1'b1;
    @(negedge clk);
    t_abort[1] = 1'b0;
    t_start[1] = 1'b0;
    n_checks++; if (m_busy !== 1'b0) $display("FAIL abort_start_busy got %b exp 0", m_busy); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) $display("FAIL abort_start_valid got %b exp 0", m_valid); else n_pass++;
    t_ready[1] = 1'b0;
    test_stream(1, 1);
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int got, dones, extra;
    sel = 1;
    push_matrix();
    t_ready[1] = 1'b1;
    pulse_start();
    got = 0; dones = 0;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      t_start[1] = m_busy && (c % 7 == 3);
      if (m_valid) begin
        if (q.size() == 0) begin
          n_checks++; $display("FAIL ign_extra got %h exp none", m_data);
        end else begin
          e = q.pop_front();
          n_checks++; if (m_data !== e.d) $display("FAIL ign_data got %h exp %h", m_data, e.d); else n_pass++;
          got++;
        end
      end
      if (m_done) begin
        dones++;
        t_start[1] = 1'b1;
      end
    end
    @(negedge clk);
    t_start[1] = 1'b0;
    n_checks++; if (m_busy !== 1'b0) $display("FAIL ign_done_start got busy %b exp 0", m_busy); else n_pass++;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) extra++;
      if (m_done) dones++;
    end
    n_checks++; if (got != 25)   $display("FAIL ign_count got %0d exp 25", got);    else n_pass++;
    n_checks++; if (extra != 0)  $display("FAIL ign_restart got %0d exp 0", extra); else n_pass++;
    n_checks++; if (dones != 1)  $display("FAIL ign_dones got %0d exp 1", dones);   else n_pass++;
    t_ready[1] = 1'b0;
  endtask

  task automatic test_async_reset();
    sel = 1;
    t_ready[1] = 1'b1;
    pulse_start();
    repeat (10) @(negedge clk);
    n_checks++; if (m_busy !== 1'b1) $display("FAIL areset_pre_busy got %b exp 1", m_busy); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (m_busy !== 1'b0)  $display("FAIL areset_busy got %b exp 0", m_busy);   else n_pass++;
    n_checks++; if (m_done !== 1'b0)  $display("FAIL areset_done got %b exp 0", m_done);   else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL areset_valid got %b exp 0", m_valid); else n_pass++;
    n_checks++; if (m_addr !== 5'd0)  $display("FAIL areset_addr got %0d exp 0", m_addr);  else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    t_ready[1] = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (m_busy !== 1'b0) $display("FAIL areset_release_busy got %b exp 0", m_busy); else n_pass++;
  endtask

  task automatic test_latency();
    test_stream(0, 0);
    test_stream(2, 3);
  endtask

  initial begin
    reset   = 1'b0;
    t_start = '0;
    t_abort = '0;
    t_ready = '0;
    sel     = 1;
    test_reset();
    test_stream(1, 1);
    test_stall();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
